inkeypad: RTL



---
 rtl/inkeypad_if.sv | 29 ++
 rtl/inkeypad.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inkeypad_if.sv
// Bus-side signal bundle of the hex keypad input unit.
// The CPU side (master) drives ko; the keypad unit (slave) returns the byte,
// the bus enable, the ready flag and the per-key strobe/code.
interface inkeypad_if;
  logic       ko;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       ready;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (
    output ko,
    input  bus_out,
    input  bus_oe,
    input  ready,
    input  key_valid,
    input  key_code
  );

  modport slave (
    input  ko,
    output bus_out,
    output bus_oe,
    output ready,
    output key_valid,
    output key_code
  );
endinterface

// File: rtl/inkeypad.sv
// Hex keypad input unit: scans a 4x4 active-low matrix one column at a time,
// debounces presses and releases, and packs two hex keys into a byte that is
// placed on the shared bus while ko is high.
// Optional build macro ENTRY_TIMEOUT_EN: abandons a half-entered byte after
// TIMEOUT_CYCLES clocks without a second key.
module inkeypad #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  inkeypad_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic             IMM_ACCEPT = (DEBOUNCE_SCANS == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Lowest-numbered low row wins when several keys share a column.
  function automatic logic [1:0] low_row_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    casez (r)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [DIV_W-1:0]   div_r;
  logic [1:0]         col_idx_r, col_idx_nxt_s;
  logic [3:0]         col_r;
  logic [3:0]         cand_r;
  logic [1:0]         cand_row_r;
  logic [CNT_W-1:0]   stable_r, stable_nxt_s, stable_inc_s;
  logic [CNT_W-1:0]   rel_r, rel_nxt_s, rel_inc_s;
  logic [3:0]         entry_r;
  logic               nib_r;
  logic [7:0]         data_r;
  logic               ready_r;
  logic               key_valid_r;
  logic [3:0]         key_code_r;

  logic               sample_s, row_hit_s, same_row_s;
  logic [1:0]         row_idx_s;
  logic               capture_s, accept_s, advance_s;
  logic [3:0]         accept_code_s;

  assign sample_s      = (div_r == DIV_LAST);
  assign row_hit_s     = (row != 4'hF);
  assign row_idx_s     = low_row_idx(row);
  assign same_row_s    = row_hit_s && (row_idx_s == cand_row_r);
  assign stable_inc_s  = stable_r + CNT_W'(1);
  assign rel_inc_s     = rel_r + CNT_W'(1);
  // With single-sample debounce the key is accepted before cand_r is loaded.
  assign accept_code_s = capture_s ? {row_idx_s, col_idx_r} : cand_r;
  assign col_idx_nxt_s = advance_s ? (col_idx_r + 2'd1) : col_idx_r;

  // State register of the scan/debounce FSM.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: moves only on sample cycles.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_s && row_hit_s) begin
          state_nxt_s = IMM_ACCEPT ? ST_HELD : ST_DEBOUNCE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (sample_s) begin
          if (same_row_s) begin
            state_nxt_s = (stable_inc_s == CNT_TARGET) ? ST_HELD : ST_DEBOUNCE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DEBOUNCE;
        end
      end
      ST_HELD: begin
        if (sample_s && !row_hit_s && (rel_inc_s == CNT_TARGET)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control decode: capture/accept/advance strobes and debounce counter updates.
  always_comb begin
    capture_s    = 1'b0;
    accept_s     = 1'b0;
    advance_s    = 1'b0;
    stable_nxt_s = stable_r;
    rel_nxt_s    = rel_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_s) begin
          if (row_hit_s) begin
            capture_s    = 1'b1;
            accept_s     = IMM_ACCEPT;
            stable_nxt_s = CNT_W'(1);
            rel_nxt_s    = '0;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      ST_DEBOUNCE: begin
        if (sample_s) begin
          if (same_row_s) begin
            stable_nxt_s = stable_inc_s;
            accept_s     = (stable_inc_s == CNT_TARGET);
            rel_nxt_s    = '0;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      ST_HELD: begin
        if (sample_s) begin
          if (!row_hit_s) begin
            rel_nxt_s = rel_inc_s;
            advance_s = (rel_inc_s == CNT_TARGET);
          end else begin
            rel_nxt_s = '0;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        advance_s = 1'b0;
      end
    endcase
  end

  // Column scan timing, column index and registered column drive.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_r     <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else begin
      div_r     <= sample_s ? '0 : (div_r + DIV_W'(1));
      col_idx_r <= col_idx_nxt_s;
      col_r     <= ~(4'b0001 << col_idx_nxt_s);
    end
  end

  // Candidate key and debounce/release counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      cand_r     <= 4'h0;
      cand_row_r <= 2'd0;
      stable_r   <= '0;
      rel_r      <= '0;
    end else begin
      if (capture_s) begin
        cand_r     <= {row_idx_s, col_idx_r};
        cand_row_r <= row_idx_s;
      end
      stable_r <= stable_nxt_s;
      rel_r    <= rel_nxt_s;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_s;

  assign timeout_s = nib_r && (to_cnt_r == TO_LAST);

  // Idle time since the first nibble; restarts on every accepted key.
  always_ff @(posedge clk) begin
    if (clr) begin
      to_cnt_r <= '0;
    end else if (accept_s || !nib_r || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  logic timeout_s;
  logic timeout_unused_s;

  assign timeout_s        = 1'b0;
  assign timeout_unused_s = TIMEOUT_CYCLES[0];
`endif

  // Nibble assembly, byte register, ready flag and key strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      entry_r     <= 4'h0;
      nib_r       <= 1'b0;
      data_r      <= 8'h00;
      ready_r     <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      key_valid_r <= accept_s;
      if (accept_s) begin
        key_code_r <= accept_code_s;
        if (!nib_r) begin
          entry_r <= accept_code_s;
          nib_r   <= 1'b1;
        end else begin
          data_r <= {entry_r, accept_code_s};
          nib_r  <= 1'b0;
        end
      end else if (timeout_s) begin
        entry_r <= 4'h0;
        nib_r   <= 1'b0;
      end else begin
        nib_r <= nib_r;
      end
      // A completing byte beats a simultaneous read.
      if (accept_s && nib_r) begin
        ready_r <= 1'b1;
      end else if (bus.ko) begin
        ready_r <= 1'b0;
      end else begin
        ready_r <= ready_r;
      end
    end
  end

  assign col           = col_r;
  assign bus.bus_oe    = bus.ko;
  assign bus.bus_out   = bus.ko ? data_r : 8'h00;
  assign bus.ready     = ready_r;
  assign bus.key_valid = key_valid_r;
  assign bus.key_code  = key_code_r;

endmodule
